// File: rtl/frame_max_min_tracker.sv
// Per-frame max/min tracker: resolves each frame's max, min, first max index and max count
// over FRAME_LEN unsigned samples, and returns the result through a valid/ready handshake.
module frame_max_min_tracker #(
  parameter int WIDTH     = 8,
  parameter int FRAME_LEN = 16,
  parameter int IDX_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [WIDTH-1:0] out_min,
  output logic [IDX_W-1:0] out_max_idx,
  output logic [IDX_W:0]   out_max_cnt,
  output logic             busy
);

  // state   | meaning
  // IDLE    | waiting for start, no sample or result traffic
  // COLLECT | accepting samples k = 0 .. FRAME_LEN-1
  // RESULT  | frame result presented until out_ready
  typedef enum logic [1:0] {IDLE, COLLECT, RESULT} state_e;
  typedef enum logic [1:0] {CMP_L, CMP_E, CMP_G} cmp_e;

  state_e           state_q;
  logic [IDX_W-1:0] k_q;
  logic [WIDTH-1:0] max_q, max_d;
  logic [WIDTH-1:0] min_q, min_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] out_max_q, out_min_q;
  logic [IDX_W-1:0] out_idx_q;
  logic [IDX_W:0]   out_cnt_q;
  cmp_e             cmp_max, cmp_min;
  logic             accept, last;

  // MSB-first unsigned magnitude compare: the first differing bit decides.
  function automatic cmp_e mag_cmp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    cmp_e r;
    r = CMP_E;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (r == CMP_E && a[i] != b[i]) r = a[i] ? CMP_G : CMP_L;
    end
    return r;
  endfunction

  assign cmp_max = mag_cmp(in_data, max_q);
  assign cmp_min = mag_cmp(in_data, min_q);
  assign accept  = (state_q == COLLECT) && in_valid;
  assign last    = (k_q == IDX_W'(FRAME_LEN - 1));

  always_comb begin
    max_d = max_q;
    min_d = min_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    if (k_q == '0) begin
      max_d = in_data;
      min_d = in_data;
      idx_d = '0;
      cnt_d = (IDX_W+1)'(1);
    end else begin
      case (cmp_max)
        CMP_G: begin
          max_d = in_data;
          idx_d = k_q;
          cnt_d = (IDX_W+1)'(1);
        end
        CMP_E:   cnt_d = cnt_q + (IDX_W+1)'(1);
        default: ;
      endcase
      if (cmp_min == CMP_L) min_d = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      k_q       <= '0;
      max_q     <= '0;
      min_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      out_max_q <= '0;
      out_min_q <= '0;
      out_idx_q <= '0;
      out_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= COLLECT;
            k_q     <= '0;
          end
        end
        COLLECT: begin
          if (accept) begin
            max_q <= max_d;
            min_q <= min_d;
            idx_q <= idx_d;
            cnt_q <= cnt_d;
            k_q   <= k_q + IDX_W'(1);
            // Publish the final-sample update directly so the result is valid one cycle later.
            if (last) begin
              state_q   <= RESULT;
              out_max_q <= max_d;
              out_min_q <= min_d;
              out_idx_q <= idx_d;
              out_cnt_q <= cnt_d;
            end
          end
        end
        RESULT: begin
          if (out_ready) begin
            state_q <= start ? COLLECT : IDLE;
            k_q     <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == COLLECT);
  assign out_valid   = (state_q == RESULT);
  assign busy        = (state_q != IDLE);
  assign out_max     = out_max_q;
  assign out_min     = out_min_q;
  assign out_max_idx = out_idx_q;
  assign out_max_cnt = out_cnt_q;

endmodule

// File: tb/tb_frame_max_min_tracker.sv
// Scoreboard bench for frame_max_min_tracker: frames are modelled when driven and
// compared when the result handshake completes.
module tb_frame_max_min_tracker;

  typedef logic [7:0] frame_t [16];
  typedef struct {
    logic [7:0] mx;
    logic [7:0] mn;
    logic [3:0] idx;
    logic [4:0] cnt;
  } res_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_max, out_min;
  logic [3:0] out_max_idx;
  logic [4:0] out_max_cnt;
  logic       busy;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  res_t sb[$];

  frame_max_min_tracker #(.WIDTH(8), .FRAME_LEN(16), .IDX_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_max(out_max), .out_min(out_min), .out_max_idx(out_max_idx),
    .out_max_cnt(out_max_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic res_t model(input frame_t s);
    res_t r;
    r.mx = s[0]; r.mn = s[0]; r.idx = 0; r.cnt = 0;
    for (int i = 1; i < 16; i++) begin
      if (s[i] > r.mx) begin r.mx = s[i]; r.idx = 4'(i); end
      if (s[i] < r.mn) r.mn = s[i];
    end
    for (int i = 0; i < 16; i++) if (s[i] == r.mx) r.cnt++;
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) check("sb_underflow", 1, 0);
      else begin
        res_t e;
        e = sb.pop_front();
        check("max", out_max, e.mx);
        check("min", out_min, e.mn);
        check("idx", out_max_idx, e.idx);
        check("cnt", out_max_cnt, e.cnt);
      end
    end
  end

  always @(posedge clk) begin
    cyc++;
    if (cyc > 20000) begin
      $display("FAIL watchdog: got %0d cycles expected <= 20000", cyc);
      $fatal(1);
    end
  end

  // Drives one frame from IDLE (do_start) or from an already-entered COLLECT.
  task automatic drive_frame(input frame_t s, input bit do_start, input bit stall);
    sb.push_back(model(s));
    if (do_start) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    for (int i = 0; i < 16; i++) begin
      if (stall) begin
        in_valid = 1'b0; in_data = 8'h00;
        @(posedge clk); #1;
      end
      in_valid = 1'b1; in_data = s[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("lat_out_valid", out_valid, 1);
    check("result_in_ready", in_ready, 0);
  endtask

  frame_t f;
  res_t   e5;

  initial begin
    #2;
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_max", out_max, 0);
    check("rst_out_cnt", out_max_cnt, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_in_ready", in_ready, 0);

    // Ramp 0..15
    for (int i = 0; i < 16; i++) f[i] = 8'(i);
    drive_frame(f, 1, 0);
    @(posedge clk); #1;
    check("ramp_idle", busy, 0);

    // Reset mid-COLLECT at k=5
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 8'(50 + i);
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_in_ready", in_ready, 0);
    check("arst_out_max", out_max, 0);
    check("arst_out_min", out_min, 0);
    check("arst_out_idx", out_max_idx, 0);
    check("arst_out_cnt", out_max_cnt, 0);
    in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Ties on the max
    f = '{7, 200, 3, 200, 200, 9, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    drive_frame(f, 1, 0);
    @(posedge clk); #1;

    // All 0xFF with in_valid stalls every other cycle
    for (int i = 0; i < 16; i++) f[i] = 8'hFF;
    drive_frame(f, 1, 1);
    in_valid = 1'b1; in_data = 8'h00;
    @(posedge clk); #1;
    check("ff_in_ready_idle", in_ready, 0);
    in_valid = 1'b0;
    @(posedge clk); #1;

    // Held result with ignored starts, then chained back-to-back frames
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) f[i] = 8'h80;
    e5 = model(f);
    drive_frame(f, 1, 0);
    for (int i = 0; i < 10; i++) begin
      start = (i % 3 == 0);
      @(posedge clk); #1;
      start = 1'b0;
      check("hold_valid", out_valid, 1);
      check("hold_max", out_max, e5.mx);
      check("hold_cnt", out_max_cnt, e5.cnt);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("chain_in_ready", in_ready, 1);
    check("chain_out_valid", out_valid, 0);
    f[0] = 8'h00;
    for (int i = 1; i < 16; i++) f[i] = 8'hFF;
    drive_frame(f, 0, 0);
    @(posedge clk); #1;
    check("final_idle", busy, 0);

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
